// File: rtl/reversi_accel_hls_deadlock_report_unit_pkg.sv
// Shared types and helpers for the dataflow deadlock report unit.
package reversi_accel_hls_deadlock_report_unit_pkg;

   // FSM states of the report unit.
   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StQualify = 3'd1,
      StOrigin  = 3'd2,
      StWalk    = 3'd3,
      StReport  = 3'd4,
      StDone    = 3'd5
   } state_e;

   // Width of the settle counter and the saturating walk counter.
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned WCNT_W = 16;

   // Ceiling log2, used to check that ID_W can address every process.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      for (r = 0; (32'd1 << r) < n; r++) begin
      end
      return r;
   endfunction

endpackage

// File: rtl/reversi_accel_hls_deadlock_report_unit_if.sv
// Valid/ready report stream carrying the IDs of the processes in the deadlock cycle.
interface reversi_accel_hls_deadlock_report_unit_if #(
   parameter int unsigned ID_W = 2
) ();

   logic            report_valid;
   logic            report_ready;
   logic [ID_W-1:0] report_proc_id;
   logic            report_last;

   modport master (
      output report_valid,
      output report_proc_id,
      output report_last,
      input  report_ready
   );

   modport slave (
      input  report_valid,
      input  report_proc_id,
      input  report_last,
      output report_ready
   );

endinterface

// File: rtl/reversi_accel_hls_deadlock_report_unit_prio_enc.sv
// Lowest-set-bit priority encoder: index, one-hot and found flag.
module reversi_accel_hls_deadlock_report_unit_prio_enc #(
   parameter int unsigned PROC_NUM = 4,
   parameter int unsigned ID_W     = 2
) (
   input  logic [PROC_NUM-1:0] vec,
   output logic [ID_W-1:0]     index,
   output logic [PROC_NUM-1:0] onehot,
   output logic                found
);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      index  = '0;
      onehot = '0;
      found  = 1'b0;
      for (int i = PROC_NUM - 1; i >= 0; i--) begin
         if (vec[i]) begin
            index     = ID_W'(i);
            onehot    = '0;
            onehot[i] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reversi_accel_hls_deadlock_report_unit.sv
// Deadlock report unit: qualifies detect flags, picks an origin, walks the token around
// the dependency cycle and streams the visited process IDs out through the report port.
module reversi_accel_hls_deadlock_report_unit
   import reversi_accel_hls_deadlock_report_unit_pkg::*;
#(
   parameter int unsigned PROC_NUM      = 4,
   parameter int unsigned ID_W          = 2,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned WALK_TIMEOUT  = 64
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [PROC_NUM-1:0]  dl_detect_in,
   input  logic [PROC_NUM-1:0]  token_arrive,
   output logic [PROC_NUM-1:0]  origin,
   output logic [PROC_NUM-1:0]  token_clear,
   output logic                 dl_detect_out,
   reversi_accel_hls_deadlock_report_unit_if.master report,
   output logic                 report_timeout,
   output logic                 deadlock_sticky
);

   if (ID_W < clog2(PROC_NUM)) begin : g_id_w_check
      $error("ID_W is too narrow to address PROC_NUM processes");
   end

   state_e              state_q, state_d;
   logic [PROC_NUM-1:0] cap_q, cap_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d, wcnt_inc;
   logic [PROC_NUM-1:0] visited_q, visited_d;
   logic [PROC_NUM-1:0] org_q, org_d;
   logic [PROC_NUM-1:0] origin_q, origin_d;
   logic [PROC_NUM-1:0] token_clear_q, token_clear_d;
   logic                dl_q, dl_d;
   logic                timeout_q, timeout_d;
   logic                sticky_q, sticky_d;
   logic                valid_q, valid_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic                last_q, last_d;

   logic                take_origin, go_report;
   logic [PROC_NUM-1:0] org_vec, org_oh, rep_oh;
   logic [ID_W-1:0]     org_idx, rep_idx;
   logic                org_found, rep_found;
   logic                unused_org_idx;

   // In IDLE with a one-cycle settle the capture register is not loaded yet.
   assign org_vec = (state_q == StIdle) ? dl_detect_in : cap_q;

   reversi_accel_hls_deadlock_report_unit_prio_enc #(
      .PROC_NUM (PROC_NUM),
      .ID_W     (ID_W)
   ) u_origin_enc (
      .vec    (org_vec),
      .index  (org_idx),
      .onehot (org_oh),
      .found  (org_found)
   );

   // Report beats are registered, so the encoder looks at next-cycle visited.
   reversi_accel_hls_deadlock_report_unit_prio_enc #(
      .PROC_NUM (PROC_NUM),
      .ID_W     (ID_W)
   ) u_report_enc (
      .vec    (visited_d),
      .index  (rep_idx),
      .onehot (rep_oh),
      .found  (rep_found)
   );

   assign unused_org_idx = ^org_idx;

   assign wcnt_inc = (wcnt_q >= WCNT_W'(WALK_TIMEOUT)) ? wcnt_q : wcnt_q + 1'b1;

   // Next-state logic for the detect / walk / report sequence.
   always_comb begin
      state_d       = state_q;
      cap_d         = cap_q;
      cnt_d         = cnt_q;
      wcnt_d        = wcnt_q;
      visited_d     = visited_q;
      org_d         = org_q;
      origin_d      = '0;
      token_clear_d = '0;
      dl_d          = dl_q;
      timeout_d     = timeout_q;
      sticky_d      = sticky_q;
      take_origin   = 1'b0;
      go_report     = 1'b0;

      case (state_q)
         StIdle: begin
            if (dl_detect_in != '0) begin
               cap_d = dl_detect_in;
               if (SETTLE_CYCLES <= 1) begin
                  take_origin = 1'b1;
               end else begin
                  state_d = StQualify;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         StQualify: begin
            if (dl_detect_in == cap_q) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q + 1'b1 == CNT_W'(SETTLE_CYCLES)) begin
                  take_origin = 1'b1;
               end
            end else begin
               // No re-capture here; IDLE picks up a new value next cycle.
               state_d = StIdle;
               cnt_d   = '0;
            end
         end
         StOrigin: begin
            state_d = StWalk;
            wcnt_d  = '0;
         end
         StWalk: begin
            visited_d = visited_q | token_arrive;
            wcnt_d    = wcnt_inc;
            // wcnt_q == 0 marks WALK cycle 1, where an origin return is too early.
            if ((wcnt_q != '0) && ((token_arrive & org_q) != '0)) begin
               go_report = 1'b1;
            end else if (wcnt_inc >= WCNT_W'(WALK_TIMEOUT)) begin
               go_report = 1'b1;
               timeout_d = 1'b1;
            end
         end
         StReport: begin
            if (valid_q && report.report_ready) begin
               visited_d = visited_q & ~(PROC_NUM'(1) << id_q);
               if (last_q) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (take_origin && org_found) begin
         state_d   = StOrigin;
         origin_d  = org_oh;
         org_d     = org_oh;
         visited_d = org_oh;
         dl_d      = 1'b1;
         cnt_d     = '0;
      end

      if (go_report) begin
         state_d       = StReport;
         token_clear_d = org_q;
         sticky_d      = 1'b1;
      end
   end

   // Next report beat: lowest remaining visited bit, last when it is the only one left.
   always_comb begin
      valid_d = 1'b0;
      id_d    = '0;
      last_d  = 1'b0;
      if ((state_d == StReport) && rep_found) begin
         valid_d = 1'b1;
         id_d    = rep_idx;
         last_d  = ((visited_d & ~rep_oh) == '0);
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         cap_q         <= '0;
         cnt_q         <= '0;
         wcnt_q        <= '0;
         visited_q     <= '0;
         org_q         <= '0;
         origin_q      <= '0;
         token_clear_q <= '0;
         dl_q          <= 1'b0;
         timeout_q     <= 1'b0;
         sticky_q      <= 1'b0;
         valid_q       <= 1'b0;
         id_q          <= '0;
         last_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cap_q         <= cap_d;
         cnt_q         <= cnt_d;
         wcnt_q        <= wcnt_d;
         visited_q     <= visited_d;
         org_q         <= org_d;
         origin_q      <= origin_d;
         token_clear_q <= token_clear_d;
         dl_q          <= dl_d;
         timeout_q     <= timeout_d;
         sticky_q      <= sticky_d;
         valid_q       <= valid_d;
         id_q          <= id_d;
         last_q        <= last_d;
      end
   end

   assign origin                = origin_q;
   assign token_clear           = token_clear_q;
   assign dl_detect_out         = dl_q;
   assign report_timeout        = timeout_q;
   assign deadlock_sticky       = sticky_q;
   assign report.report_valid   = valid_q;
   assign report.report_proc_id = id_q;
   assign report.report_last    = last_q;

endmodule
